// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential signed 32x32 multiply (radix-2 Booth) and signed
//            divide (restoring division on magnitudes) for the HI/LO pair.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            start, op, a, b   - launch pulse, 0=MULT/1=DIV, operands
//            busy, done, div0  - registered status outputs
//            hi, lo            - result registers (product / rem,quo)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_Z    = 3'd4;

    localparam logic [4:0] c_LAST = 5'(ITER - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [4:0]  r_cnt;
    logic        r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    // Shared datapath: acc is the Booth accumulator or the remainder,
    // mq is the multiplier or the quotient, md the multiplicand or |b|.
    logic [32:0] r_acc;
    logic [31:0] r_mq;
    logic        r_q1;
    logic [32:0] r_md;

    logic        w_last;
    logic        w_done_d;
    logic        w_div0_d;
    logic        w_busy_d;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_booth_sum;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_last = (r_cnt == c_LAST);

    // |0x80000000| wraps back to 0x80000000, which is the right unsigned value.
    assign w_abs_a = a[31] ? (32'd0 - a) : a;
    assign w_abs_b = b[31] ? (32'd0 - b) : b;

    always_comb begin
        case ({r_mq[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_md;
            2'b10:   w_booth_sum = r_acc - r_md;
            default: w_booth_sum = r_acc;
        endcase
    end

    // The shifted partial remainder is below 2*|b| <= 2^32, so bit 32 of the
    // trial difference is a valid sign bit.
    assign w_shift = {r_acc[31:0], r_mq[31]};
    assign w_trial = w_shift - r_md;
    assign w_ge    = ~w_trial[32];

    assign w_quo = (r_sign_a ^ r_sign_b) ? (32'd0 - r_mq) : r_mq;
    assign w_rem = r_sign_a ? (32'd0 - r_acc[31:0]) : r_acc[31:0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op)             w_next_state = S_MULT;
                    else if (b == 32'd0) w_next_state = S_Z;
                    else                 w_next_state = S_DIV;
                end
            end
            S_MULT:  if (w_last) w_next_state = S_FIN;
            S_DIV:   if (w_last) w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            S_Z:     w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: busy stays up through the done cycle so that it falls
    // together with done.
    always_comb begin
        w_done_d = (r_state == S_FIN) || (r_state == S_Z);
        w_div0_d = (r_state == S_Z);
        w_busy_d = (w_next_state != S_IDLE) || w_done_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
        end else begin
            busy <= w_busy_d;
            done <= w_done_d;
            div0 <= w_div0_d;
        end
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= 33'd0;
            r_mq     <= 32'd0;
            r_q1     <= 1'b0;
            r_md     <= 33'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_sign_a <= a[31];
                        r_sign_b <= b[31];
                        r_cnt    <= 5'd0;
                        r_q1     <= 1'b0;
                        r_acc    <= 33'd0;
                        if (!op) begin
                            r_md <= {a[31], a};
                            r_mq <= b;
                        end else begin
                            r_md <= {1'b0, w_abs_b};
                            r_mq <= w_abs_a;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= {w_booth_sum[32], w_booth_sum[32:1]};
                    r_mq  <= {w_booth_sum[0], r_mq[31:1]};
                    r_q1  <= r_mq[0];
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_acc <= w_ge ? w_trial : w_shift;
                    r_mq  <= {r_mq[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIN: begin
                    if (r_op) begin
                        hi <= w_rem;
                        lo <= w_quo;
                    end else begin
                        hi <= r_acc[31:0];
                        lo <= r_mq;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
